// File: rtl/control_sequencer.sv
// Five-step T-state sequencer for an 8-bit microcoded CPU.
// Decodes step, opcode and flags into the datapath control strobes.
module control_sequencer (
   input  logic       clk,
   input  logic       clear,
   input  logic [3:0] opcode,
   input  logic       carry_flag,
   input  logic       zero_flag,
   output logic [2:0] step,
   output logic       halt,
   output logic       load_addr_reg,
   output logic       write_enable,
   output logic       output_enable,
   output logic       ir_load,
   output logic       ir_out,
   output logic       a_load,
   output logic       a_out,
   output logic       b_load,
   output logic       alu_out,
   output logic       alu_sub,
   output logic       flags_load,
   output logic       out_load,
   output logic       pc_inc,
   output logic       pc_out,
   output logic       pc_jump
);

   localparam logic [3:0] OP_LDA = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_SUB = 4'b0011;
   localparam logic [3:0] OP_STA = 4'b0100;
   localparam logic [3:0] OP_LDI = 4'b0101;
   localparam logic [3:0] OP_JMP = 4'b0110;
   localparam logic [3:0] OP_JC  = 4'b0111;
   localparam logic [3:0] OP_JZ  = 4'b1000;
   localparam logic [3:0] OP_OUT = 4'b1110;
   localparam logic [3:0] OP_HLT = 4'b1111;

   typedef enum logic [1:0] {
      ST_ARM,
      ST_RUN,
      ST_HALT
   } state_t;

   state_t     state_q, state_d;
   logic [2:0] step_q, step_d;

   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         state_q <= ST_ARM;
         step_q  <= 3'd0;
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
      end
   end

   assign step = step_q;

   // ST_ARM holds T0 for one extra edge after clear is released
   always_comb begin
      state_d = state_q;
      step_d  = step_q;
      unique case (state_q)
         ST_ARM: state_d = ST_RUN;
         ST_RUN: begin
            if (step_q == 3'd2 && opcode == OP_HLT)
               state_d = ST_HALT;
            else if (step_q >= 3'd4)
               step_d = 3'd0;
            else
               step_d = step_q + 3'd1;
         end
         ST_HALT: state_d = ST_HALT;
         default: begin
            state_d = ST_ARM;
            step_d  = 3'd0;
         end
      endcase
   end

   always_comb begin
      halt          = 1'b0;
      load_addr_reg = 1'b1;
      write_enable  = 1'b1;
      output_enable = 1'b0;
      ir_load       = 1'b0;
      ir_out        = 1'b0;
      a_load        = 1'b0;
      a_out         = 1'b0;
      b_load        = 1'b0;
      alu_out       = 1'b0;
      alu_sub       = 1'b0;
      flags_load    = 1'b0;
      out_load      = 1'b0;
      pc_inc        = 1'b0;
      pc_out        = 1'b0;
      pc_jump       = 1'b0;
      if (!clear) begin
         if (state_q == ST_HALT) begin
            halt = 1'b1;
         end else begin
            unique case (1'b1)
               step_q == 3'd0: begin
                  pc_out        = 1'b1;
                  load_addr_reg = 1'b0;
               end
               step_q == 3'd1: begin
                  output_enable = 1'b1;
                  ir_load       = 1'b1;
                  pc_inc        = 1'b1;
               end
               step_q == 3'd2: begin
                  case (opcode)
                     OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                        ir_out        = 1'b1;
                        load_addr_reg = 1'b0;
                     end
                     OP_LDI: begin
                        ir_out = 1'b1;
                        a_load = 1'b1;
                     end
                     OP_JMP: begin
                        ir_out  = 1'b1;
                        pc_jump = 1'b1;
                     end
                     OP_JC: begin
                        ir_out  = carry_flag;
                        pc_jump = carry_flag;
                     end
                     OP_JZ: begin
                        ir_out  = zero_flag;
                        pc_jump = zero_flag;
                     end
                     OP_OUT: begin
                        a_out    = 1'b1;
                        out_load = 1'b1;
                     end
                     OP_HLT: halt = 1'b1;
                     default: ;
                  endcase
               end
               step_q == 3'd3: begin
                  case (opcode)
                     OP_LDA: begin
                        output_enable = 1'b1;
                        a_load        = 1'b1;
                     end
                     OP_ADD, OP_SUB: begin
                        output_enable = 1'b1;
                        b_load        = 1'b1;
                     end
                     OP_STA: begin
                        a_out        = 1'b1;
                        write_enable = 1'b0;
                     end
                     default: ;
                  endcase
               end
               step_q == 3'd4: begin
                  if (opcode == OP_ADD || opcode == OP_SUB) begin
                     alu_out    = 1'b1;
                     a_load     = 1'b1;
                     flags_load = 1'b1;
                     alu_sub    = (opcode == OP_SUB);
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule
